mobo_mem_ctrl: RTL

MOBO_MEM_CTRL -- requirements
Module: mobo_mem_ctrl

---
 rtl/mobo_mem_ctrl_pkg.sv | 31 +++
 rtl/mobo_mem_ctrl_if.sv | 15 +
 rtl/mobo_mem_ctrl_mem_array.sv | 37 +++
 rtl/mobo_mem_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mobo_mem_ctrl_pkg.sv
// rtl/mobo_mem_ctrl_pkg.sv - shared mobo command/status codes and controller state type
// Purpose: CPU<->memory mailbox codes (CTRL_*, STAT_*) and the controller FSM state enum.
// Ports: none (package). Provides the `WORD_WIDTH default (16) when not set by the build.
// Optional feature macro used by importers: MOBO_ADDR_CHECK_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package mobo_mem_ctrl_pkg;

    localparam int MOBO_WORD_WIDTH = `WORD_WIDTH;

    // Commands driven by the CPU on mobo_ctrl
    localparam int CTRL_NONE  = 0;
    localparam int CTRL_READ  = 1;
    localparam int CTRL_WRITE = 2;

    // Status reported on mobo_stat; values match the state encoding below
    localparam int STAT_IDLE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_DONE = 2;
    localparam int STAT_ERR  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } mobo_state_e;

endpackage

// File: rtl/mobo_mem_ctrl_if.sv
// rtl/mobo_mem_ctrl_if.sv - CPU mailbox bus between CPU registers and the memory controller
// Purpose: bundles mobo_ctrl/mobo_stat/addr/dat_in/dat_out.
// Modports: master (CPU side: drives ctrl/addr/dat_in), slave (controller side: drives stat/dat_out).
interface mobo_mem_ctrl_if #(
    parameter int WORD_WIDTH = `WORD_WIDTH
);
    logic [WORD_WIDTH-1:0] mobo_ctrl;
    logic [WORD_WIDTH-1:0] mobo_stat;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] dat_in;
    logic [WORD_WIDTH-1:0] dat_out;

    modport master (output mobo_ctrl, addr, dat_in, input mobo_stat, dat_out);
    modport slave  (input mobo_ctrl, addr, dat_in, output mobo_stat, dat_out);
endinterface

// File: rtl/mobo_mem_ctrl_mem_array.sv
// rtl/mobo_mem_ctrl_mem_array.sv - MEM_DEPTH x WORD_WIDTH backing store
// Purpose: synchronous write, registered read; read register holds until the next read.
// Ports: clk, rst (sync, active-low, clears the read register only), we_i, re_i,
//        addr_i, wdata_i, rdata_o.
module mobo_mem_array #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);
    logic [WORD_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mobo_mem_ctrl.sv
// rtl/mobo_mem_ctrl.sv - CPU mailbox memory controller with four-phase handshake
// Purpose: accepts READ/WRITE in IDLE, waits WAIT_CYCLES in BUSY, accesses memory on
//          entry to DONE, returns to IDLE once the CPU drops to CTRL_NONE.
// Ports: clk, rst (sync, active-low), bus (mobo_mem_ctrl_if.slave).
// Macro: MOBO_ADDR_CHECK_EN - out-of-range addresses go to S_ERR instead of wrapping.
module mobo_mem_ctrl
    import mobo_mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mobo_mem_ctrl_if.slave  bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [WORD_WIDTH-1:0] C_NONE  = WORD_WIDTH'(CTRL_NONE);
    localparam logic [WORD_WIDTH-1:0] C_READ  = WORD_WIDTH'(CTRL_READ);
    localparam logic [WORD_WIDTH-1:0] C_WRITE = WORD_WIDTH'(CTRL_WRITE);

    mobo_state_e           state_q;
    logic [WORD_WIDTH-1:0] stat_q;
    logic [WORD_WIDTH-1:0] cmd_q;
    logic [AW-1:0]         addr_q;
    logic [WORD_WIDTH-1:0] wdat_q;
    logic [CW-1:0]         cnt_q;

    logic                  accept;
    logic                  addr_bad;
    logic                  direct;
    logic                  finish;
    logic                  mem_we;
    logic                  mem_re;
    logic [AW-1:0]         mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  unused_addr;

    assign accept = (state_q == S_IDLE) && ((bus.mobo_ctrl == C_READ) || (bus.mobo_ctrl == C_WRITE));

`ifdef MOBO_ADDR_CHECK_EN
    assign addr_bad = ({32'd0, bus.addr} >= (WORD_WIDTH + 32)'(MEM_DEPTH));
`else
    assign addr_bad = 1'b0;
`endif
    // Upper address bits only matter to the range check; they are dropped otherwise.
    assign unused_addr = ^bus.addr;

    // With no wait states the access happens on the accept edge from the live inputs;
    // otherwise it happens on the last BUSY edge from the latched copies.
    assign direct    = accept && !addr_bad && (WAIT_CYCLES == 0);
    assign finish    = (state_q == S_BUSY) && (cnt_q == '0);
    assign mem_we    = rst && ((direct && bus.mobo_ctrl == C_WRITE) || (finish && cmd_q == C_WRITE));
    assign mem_re    = rst && ((direct && bus.mobo_ctrl == C_READ)  || (finish && cmd_q == C_READ));
    assign mem_addr  = direct ? bus.addr[AW-1:0] : addr_q;
    assign mem_wdata = direct ? bus.dat_in : wdat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            stat_q  <= WORD_WIDTH'(STAT_IDLE);
            cmd_q   <= C_NONE;
            addr_q  <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q  <= bus.mobo_ctrl;
                        addr_q <= bus.addr[AW-1:0];
                        wdat_q <= bus.dat_in;
                        cnt_q  <= CNT_LOAD;
                        if (addr_bad) begin
                            state_q <= S_ERR;
                            stat_q  <= WORD_WIDTH'(STAT_ERR);
                        end else if (WAIT_CYCLES == 0) begin
                            state_q <= S_DONE;
                            stat_q  <= WORD_WIDTH'(STAT_DONE);
                        end else begin
                            state_q <= S_BUSY;
                            stat_q  <= WORD_WIDTH'(STAT_BUSY);
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        stat_q  <= WORD_WIDTH'(STAT_DONE);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.mobo_ctrl == C_NONE) begin
                        state_q <= S_IDLE;
                        stat_q  <= WORD_WIDTH'(STAT_IDLE);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    stat_q  <= WORD_WIDTH'(STAT_IDLE);
                end
            endcase
        end
    end

    mobo_mem_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.mobo_stat = stat_q;
    assign bus.dat_out   = mem_rdata;
endmodule
